// File: rtl/pwm_generator.sv
// Multi-channel PWM engine: a shared prescaler and period counter feed NUM_CH
// comparators whose duty values are shadowed and reloaded only at period wrap.
module pwm_generator #(
   parameter int NUM_CH   = 4,
   parameter int DUTY_W   = 8,
   parameter int PRESCALE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pwm_cfg,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start
);

   localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
   localparam int              USED_W    = NUM_CH * DUTY_W;

   logic [PW-1:0]     presc_reg;
   logic [PW-1:0]     presc_next;
   logic [DUTY_W-1:0] cnt_reg;
   logic [DUTY_W-1:0] cnt_next;
   logic              tick;
   logic              wrap;
   logic              period_start_reg;

   always_comb begin
      tick       = (presc_reg == PRESC_MAX);
      presc_next = tick ? '0 : presc_reg + PW'(1);
      cnt_next   = tick ? cnt_reg + DUTY_W'(1) : cnt_reg;
      wrap       = tick && (&cnt_reg);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg        <= '0;
         cnt_reg          <= '0;
         period_start_reg <= 1'b0;
      end else begin
         presc_reg        <= presc_next;
         cnt_reg          <= cnt_next;
         period_start_reg <= wrap;
      end
   end

   assign period_start = period_start_reg;

   // The comparator looks at the values being loaded this edge so the output
   // register lines up with cnt rather than trailing it by one clock.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DUTY_W-1:0] shadow_reg;
         logic [DUTY_W-1:0] shadow_next;
         logic              out_reg;

         always_comb begin
            shadow_next = wrap ? pwm_cfg[gi*DUTY_W +: DUTY_W] : shadow_reg;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               shadow_reg <= '0;
               out_reg    <= 1'b0;
            end else begin
               shadow_reg <= shadow_next;
               out_reg    <= (cnt_next < shadow_next);
            end
         end

         assign pwm_out[gi] = out_reg;
      end

      // Config bits beyond the active channels carry no meaning here.
      if (USED_W < 32) begin : g_spare
         logic unused_cfg_bits;
         assign unused_cfg_bits = ^pwm_cfg[31:USED_W];
      end
   endgenerate

endmodule
